// File: rtl/z80_bus_ctrl_if.sv
// z80_bus_ctrl_if: bundle of the Z80-side bus, the memory req/ack port and the
// on-block I/O port signals seen by z80_bus_ctrl.
//   slave  modport: the bus controller (decodes the CPU cycle, drives DI/WAIT,
//                   the memory request side and the output port register).
//   master modport: the environment (CPU, memory and I/O pins).
// Signals:
//   ADDR/DO/WR/MREQ/IORQ/M1  CPU cycle inputs to the controller
//   DI/WAIT                  data and stall back to the CPU
//   MEM_REQ/MEM_WE/MEM_ADDR/MEM_WDATA  memory request, held until MEM_ACK
//   MEM_RDATA/MEM_ACK        memory read data and single-cycle completion
//   IO_OUT/IO_IN             output port register and input port value
interface z80_bus_ctrl_if;
    logic [15:0] ADDR;
    logic [7:0]  DO;
    logic        WR;
    logic        MREQ;
    logic        IORQ;
    logic        M1;
    logic [7:0]  DI;
    logic        WAIT;
    logic        MEM_REQ;
    logic        MEM_WE;
    logic [15:0] MEM_ADDR;
    logic [7:0]  MEM_WDATA;
    logic [7:0]  MEM_RDATA;
    logic        MEM_ACK;
    logic [7:0]  IO_OUT;
    logic [7:0]  IO_IN;

    modport slave (
        input  ADDR, DO, WR, MREQ, IORQ, M1, MEM_RDATA, MEM_ACK, IO_IN,
        output DI, WAIT, MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, IO_OUT
    );

    modport master (
        output ADDR, DO, WR, MREQ, IORQ, M1, MEM_RDATA, MEM_ACK, IO_IN,
        input  DI, WAIT, MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, IO_OUT
    );
endinterface

// File: rtl/z80_bus_ctrl.sv
// z80_bus_ctrl: Z80 bus cycle decoder.
// Bridges memory cycles to a req/ack memory port with a programmable minimum
// number of wait states, implements one 8-bit output port register and one
// input port, and answers interrupt-acknowledge cycles with a fixed vector.
// Ports:
//   CLK    system clock, rising edge
//   RESET  asynchronous, active-low reset
//   bus    z80_bus_ctrl_if.slave (CPU bus, memory port, I/O port)
// Parameters:
//   MEM_WS        minimum wait cycles per memory access (0..15)
//   IO_PORT_ADDR  low address byte of the on-block I/O port
//   INT_VECTOR    byte returned on an interrupt-acknowledge cycle
//   IO_WS         fixed wait cycles for I/O cycles (0..15)
module z80_bus_ctrl #(
    parameter int unsigned MEM_WS       = 2,
    parameter logic [7:0]  IO_PORT_ADDR = 8'h10,
    parameter logic [7:0]  INT_VECTOR   = 8'hFF,
    parameter int unsigned IO_WS        = 1
) (
    input logic           CLK,
    input logic           RESET,
    z80_bus_ctrl_if.slave bus
);

    localparam logic [3:0] MemWsCnt = 4'(MEM_WS);
    localparam logic [3:0] IoWsCnt  = 4'(IO_WS);

    typedef enum logic [1:0] {StIdle, StMem, StIo, StDone} state_e;

    state_e     state;
    logic [3:0] wait_cnt;
    logic [7:0] rdata;
    logic       ack_seen;
    logic       aborted;

    logic       ack;
    logic       cnt_expire;
    logic       port_hit;
    logic [7:0] io_rd_data;

    // Only an ack against an outstanding request counts.
    assign ack = bus.MEM_ACK && bus.MEM_REQ;

    // The counter decrement happening this cycle brings it to zero, so a memory
    // access completes max(MEM_WS, ack latency) cycles after acceptance.
    assign cnt_expire = (wait_cnt <= 4'd1);

    assign port_hit = (bus.ADDR[7:0] == IO_PORT_ADDR);

    always_comb begin
        io_rd_data = 8'hFF;
        if (bus.M1) begin
            io_rd_data = INT_VECTOR;
        end else if (port_hit) begin
            io_rd_data = bus.IO_IN;
        end
    end

    assign bus.WAIT = (bus.MREQ || bus.IORQ) && (state != StDone);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state         <= StIdle;
            wait_cnt      <= 4'd0;
            rdata         <= 8'h00;
            ack_seen      <= 1'b0;
            aborted       <= 1'b0;
            bus.DI        <= 8'h00;
            bus.MEM_REQ   <= 1'b0;
            bus.MEM_WE    <= 1'b0;
            bus.MEM_ADDR  <= 16'h0000;
            bus.MEM_WDATA <= 8'h00;
            bus.IO_OUT    <= 8'h00;
        end else begin
            unique case (state)
                StIdle: begin
                    // MREQ has priority over a simultaneous IORQ.
                    if (bus.MREQ) begin
                        state         <= StMem;
                        bus.MEM_ADDR  <= bus.ADDR;
                        bus.MEM_WDATA <= bus.DO;
                        bus.MEM_WE    <= bus.WR;
                        bus.MEM_REQ   <= 1'b1;
                        wait_cnt      <= MemWsCnt;
                        ack_seen      <= 1'b0;
                        aborted       <= 1'b0;
                    end else if (bus.IORQ) begin
                        state    <= StIo;
                        wait_cnt <= IoWsCnt;
                    end
                end

                StMem: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                    if (ack) begin
                        bus.MEM_REQ <= 1'b0;
                        ack_seen    <= 1'b1;
                        if (!bus.MEM_WE) begin
                            rdata <= bus.MEM_RDATA;
                        end
                    end
                    if (ack || ack_seen) begin
                        if (aborted || !bus.MREQ) begin
                            // Withdrawn access: data is dropped, DI untouched.
                            state <= StIdle;
                        end else if (cnt_expire) begin
                            state <= StDone;
                            if (!bus.MEM_WE) begin
                                bus.DI <= ack ? bus.MEM_RDATA : rdata;
                            end
                        end
                    end else if (!bus.MREQ) begin
                        // Keep MEM_REQ up until the memory acks, then drop out.
                        aborted <= 1'b1;
                    end
                end

                StIo: begin
                    if (!bus.IORQ) begin
                        state <= StIdle;
                    end else if (wait_cnt == 4'd0) begin
                        state <= StDone;
                        if (bus.WR && !bus.M1) begin
                            if (port_hit) begin
                                bus.IO_OUT <= bus.DO;
                            end
                        end else begin
                            bus.DI <= io_rd_data;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end

                StDone: begin
                    if (!bus.MREQ && !bus.IORQ) begin
                        state <= StIdle;
                    end
                end

                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/z80_bus_ctrl.md
Name: z80_bus_ctrl

Overview:
- Downstream consumer of the cpu_z80 bus: decodes MREQ/IORQ/WR/M1 cycles and drives the CPU's DI and WAIT inputs.
- Bridges memory cycles to a req/ack memory port, inserting a programmable minimum number of wait states.
- Holds one 8-bit output port register and one input port, and answers interrupt-acknowledge cycles with a fixed vector.

Parameters:
- MEM_WS, 2: minimum wait cycles per memory access (0..15), counted from acceptance of the request.
- IO_PORT_ADDR, 8'h10: low address byte selecting the on-block I/O port.
- INT_VECTOR, 8'hFF: byte returned on an interrupt-acknowledge cycle.
- IO_WS, 1: fixed wait cycles for I/O cycles (0..15).

Ports:
- CLK  in  1  system clock; all state is updated on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- ADDR  in  16  CPU address.
- DO  in  8  CPU write data.
- WR  in  1  CPU write strobe; 1 = write, 0 = read.
- MREQ  in  1  CPU memory request, active-high.
- IORQ  in  1  CPU I/O request, active-high.
- M1  in  1  CPU opcode-fetch / interrupt-ack qualifier, active-high.
- DI  out  8  data to the CPU.
- WAIT  out  1  stall to the CPU, active-high.
- MEM_REQ  out  1  memory request, held until MEM_ACK.
- MEM_WE  out  1  memory write enable, valid with MEM_REQ.
- MEM_ADDR  out  16  memory address, registered.
- MEM_WDATA  out  8  memory write data, registered.
- MEM_RDATA  in  8  memory read data, valid with MEM_ACK.
- MEM_ACK  in  1  single-cycle memory completion pulse.
- IO_OUT  out  8  output port register.
- IO_IN  in  8  input port value.

Behaviour:
- Reset (RESET=0, asynchronous): state IDLE, DI=8'h00, MEM_REQ=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, IO_OUT=8'h00, wait counter=0, rdata latch=0.
- WAIT is combinational: (MREQ|IORQ) && state != DONE. With no request, WAIT=0.
- States: IDLE, MEM, IO, DONE.
- IDLE:
  - MREQ=1 -> MEM. Latch ADDR into MEM_ADDR and DO into MEM_WDATA, set MEM_WE=WR, assert MEM_REQ, load counter=MEM_WS.
  - else IORQ=1 -> IO. Load counter=IO_WS.
  - MREQ and IORQ both 1: MREQ wins. IORQ is ignored until MREQ falls.
- MEM:
  - Counter decrements each cycle while nonzero.
  - MEM_REQ drops in the cycle MEM_ACK is sampled high. Latch MEM_RDATA if MEM_WE=0 and record ack-seen.
  - Go to DONE when ack-seen (or ack this cycle) and counter==0.
  - Minimum MEM-to-DONE latency is max(MEM_WS, ack latency) cycles.
  - An ack that arrives before the counter expires is held; the access does not repeat.
- IO:
  - Counter decrements; at 0 -> DONE.
  - Write (WR=1) with ADDR[7:0]==IO_PORT_ADDR and M1=0: IO_OUT<=DO on the DONE transition.
  - Interrupt ack (IORQ=1 and M1=1): DI=INT_VECTOR and WR is ignored.
  - Read of IO_PORT_ADDR: DI=IO_IN, sampled on the DONE transition.
  - Read of any other port: DI=8'hFF.
- DONE:
  - WAIT=0. DI holds the latched read data (memory, port or vector).
  - Stays in DONE while MREQ|IORQ remains 1, then returns to IDLE the cycle after both are 0.
  - A new request can therefore never be accepted in the same cycle the previous one ends (one idle cycle minimum).
- Request withdrawn mid-access (MREQ/IORQ falls before DONE):
  - Memory: keep MEM_REQ until MEM_ACK, discard the data, return to IDLE without updating DI.
  - I/O: abort to IDLE without updating IO_OUT.
- DI changes only on DONE entry or reset; it holds its value otherwise.
- Wait counters are 4 bits. MEM_WS/IO_WS=0 means no minimum: memory is ack-bound only and I/O completes in one cycle.

Test Plan:
- Reset mid memory access (MEM_REQ=1) -> all outputs at reset values immediately; WAIT=0 once MREQ is low.
- Memory read with MEM_WS=2, ADDR=16'h1234, MEM_ACK one cycle after MEM_REQ, MEM_RDATA=8'hA5 -> MEM_ADDR=16'h1234, MEM_WE=0, WAIT high for 2 cycles, DI=8'hA5 at DONE.
- Memory write with MEM_WS=0, DO=8'h3C, ACK delayed 5 cycles -> MEM_WE=1, MEM_WDATA=8'h3C, MEM_REQ held 5 cycles, WAIT deasserts the cycle after ACK.
- I/O write to port 8'h10 with DO=8'h5A -> IO_OUT=8'h5A after IO_WS+1 cycles; a write to port 8'h11 leaves IO_OUT unchanged.
- I/O reads: port 8'h10 with IO_IN=8'hC3 -> DI=8'hC3; port 8'h20 -> DI=8'hFF. Interrupt ack (IORQ=1, M1=1) -> DI=8'hFF (INT_VECTOR) and IO_OUT is untouched.
- MREQ and IORQ asserted together -> memory access only. MREQ withdrawn before ACK -> DI keeps its prior value and the FSM returns to IDLE after ACK.
